// File: rtl/creek_ctrl_pkg.sv
// Shared definitions for the creek control sequencer: register map, CTRL bits,
// FSM state encoding and the STATUS word layout.
package creek_ctrl_pkg;

    localparam int unsigned AVL_ADDR_W = 2;
    localparam int unsigned AVL_DATA_W = 32;

    localparam logic [AVL_ADDR_W-1:0] ADDR_CTRL      = 2'd0;
    localparam logic [AVL_ADDR_W-1:0] ADDR_STEPS     = 2'd1;
    localparam logic [AVL_ADDR_W-1:0] ADDR_TIMEOUT   = 2'd2;
    localparam logic [AVL_ADDR_W-1:0] ADDR_COMPLETED = 2'd3;

    localparam int unsigned CTRL_GO_BIT      = 0;
    localparam int unsigned CTRL_ABORT_BIT   = 1;
    localparam int unsigned CTRL_IRQ_CLR_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_RESUME = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4,
        ST_TOUT   = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [25:0] rsvd;
        seq_state_t  state;
        logic        irq;
        logic        timeout_flag;
        logic        busy;
    } status_t;

    // Core is actively being sequenced; config writes are locked out.
    function automatic logic is_busy(input seq_state_t s);
        return (s == ST_RUN) || (s == ST_RESUME) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/creek_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches the limit. A zero limit disables it.
module creek_watchdog
    import creek_ctrl_pkg::*;
#(
    parameter int unsigned TMO_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expire
);

    localparam int unsigned CNT_X_W = TMO_W + 1;

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (limit != '0) && (count != '1)) begin
            count <= count + TMO_W'(1);
        end
    end

    // The current enabled cycle is the limit-th one counted.
    assign expire = enable && (limit != '0) &&
                    ((CNT_X_W'(count) + CNT_X_W'(1)) >= CNT_X_W'(limit));

endmodule

// File: rtl/creek_ctrl_sequencer.sv
// Register-controlled sequencer that pauses a core and releases it a
// programmed number of times at its sync points, with a run watchdog.
module creek_ctrl_sequencer
    import creek_ctrl_pkg::*;
#(
    parameter int unsigned STEP_W = 16,
    parameter int unsigned TMO_W  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AVL_ADDR_W-1:0] avl_address,
    input  logic [AVL_DATA_W-1:0] avl_writedata,
    input  logic                  avl_write,
    input  logic                  avl_read,
    output logic [AVL_DATA_W-1:0] avl_readdata,
    output logic                  pause_n,
    output logic                  resume,
    input  logic                  waiting,
    output logic                  irq
);

    seq_state_t state, state_d;

    logic [STEP_W-1:0] steps_cfg;
    logic [STEP_W-1:0] remaining;
    logic [STEP_W-1:0] completed;
    logic [TMO_W-1:0]  timeout_cfg;
    logic              timeout_flag;

    logic busy_c, ctrl_wr_c, go_c, abort_c, irq_clr_c, steps_wr_c, tmo_wr_c;
    logic go_acc_c, step_c, set_done_c, set_tout_c;
    logic wd_clear_c, wd_en_c, wd_expire_c;
    logic pause_n_d, resume_d;
    status_t               status_c;
    logic [AVL_DATA_W-1:0] rdata_c;

    assign busy_c     = is_busy(state);
    assign ctrl_wr_c  = avl_write && (avl_address == ADDR_CTRL);
    assign go_c       = ctrl_wr_c && avl_writedata[CTRL_GO_BIT];
    assign abort_c    = ctrl_wr_c && avl_writedata[CTRL_ABORT_BIT];
    assign irq_clr_c  = ctrl_wr_c && avl_writedata[CTRL_IRQ_CLR_BIT];
    assign steps_wr_c = avl_write && (avl_address == ADDR_STEPS) && !busy_c;
    assign tmo_wr_c   = avl_write && (avl_address == ADDR_TIMEOUT) && !busy_c;
    assign wd_en_c    = (state == ST_RUN) || (state == ST_DRAIN);

    creek_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear_c),
        .enable (wd_en_c),
        .limit  (timeout_cfg),
        .expire (wd_expire_c)
    );

    // Next-state and output decode; abort beats go, sync point beats watchdog.
    always_comb begin
        state_d    = state;
        go_acc_c   = 1'b0;
        step_c     = 1'b0;
        set_done_c = 1'b0;
        set_tout_c = 1'b0;
        wd_clear_c = 1'b0;
        if (abort_c) begin
            state_d    = ST_IDLE;
            wd_clear_c = 1'b1;
        end else if (go_c && !busy_c) begin
            state_d    = ST_RUN;
            go_acc_c   = 1'b1;
            wd_clear_c = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (waiting) begin
                        if (remaining != '0) begin
                            state_d = ST_RESUME;
                            step_c  = 1'b1;
                        end else begin
                            state_d    = ST_DONE;
                            set_done_c = 1'b1;
                        end
                    end else if (wd_expire_c) begin
                        state_d    = ST_TOUT;
                        set_tout_c = 1'b1;
                    end
                end
                ST_RESUME: state_d = ST_DRAIN;
                ST_DRAIN: begin
                    if (!waiting) begin
                        state_d    = ST_RUN;
                        wd_clear_c = 1'b1;
                    end else if (wd_expire_c) begin
                        state_d    = ST_TOUT;
                        set_tout_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        pause_n_d = !((state_d == ST_IDLE) || (state_d == ST_TOUT));
        resume_d  = (state_d == ST_RESUME);
    end

    // Read mux samples pre-write state.
    always_comb begin
        status_c              = '0;
        status_c.state        = state;
        status_c.irq          = irq;
        status_c.timeout_flag = timeout_flag;
        status_c.busy         = busy_c;
        rdata_c               = '0;
        case (avl_address)
            ADDR_CTRL:      rdata_c = status_c;
            ADDR_STEPS:     rdata_c = AVL_DATA_W'(remaining);
            ADDR_TIMEOUT:   rdata_c = AVL_DATA_W'(timeout_cfg);
            ADDR_COMPLETED: rdata_c = AVL_DATA_W'(completed);
            default:        rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pause_n      <= 1'b0;
            resume       <= 1'b0;
            irq          <= 1'b0;
            timeout_flag <= 1'b0;
            steps_cfg    <= '0;
            remaining    <= '0;
            completed    <= '0;
            timeout_cfg  <= '0;
            avl_readdata <= '0;
        end else begin
            state   <= state_d;
            pause_n <= pause_n_d;
            resume  <= resume_d;

            if (steps_wr_c) begin
                steps_cfg <= STEP_W'(avl_writedata);
                remaining <= STEP_W'(avl_writedata);
            end else if (go_acc_c) begin
                remaining <= steps_cfg;
            end else if (step_c) begin
                remaining <= remaining - STEP_W'(1);
            end

            if (go_acc_c) begin
                completed <= '0;
            end else if (step_c && (completed != '1)) begin
                completed <= completed + STEP_W'(1);
            end

            if (tmo_wr_c) begin
                timeout_cfg <= TMO_W'(avl_writedata);
            end

            if (set_tout_c) begin
                timeout_flag <= 1'b1;
            end else if (go_acc_c) begin
                timeout_flag <= 1'b0;
            end

            if (set_done_c || set_tout_c) begin
                irq <= 1'b1;
            end else if (irq_clr_c || go_acc_c) begin
                irq <= 1'b0;
            end

            if (avl_read) begin
                avl_readdata <= rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_creek_ctrl_sequencer.sv
// Self-checking bench for creek_ctrl_sequencer: directed scenarios plus random
// bus/waiting traffic, all checked against a cycle-level behavioural model.
module tb_creek_ctrl_sequencer;
    import creek_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avl_address;
    logic [31:0] avl_writedata;
    logic        avl_write;
    logic        avl_read;
    logic [31:0] avl_readdata;
    logic        pause_n;
    logic        resume;
    logic        waiting;
    logic        irq;

    always #5 clk = ~clk;

    creek_ctrl_sequencer #(
        .STEP_W (16),
        .TMO_W  (24)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avl_address   (avl_address),
        .avl_writedata (avl_writedata),
        .avl_write     (avl_write),
        .avl_read      (avl_read),
        .avl_readdata  (avl_readdata),
        .pause_n       (pause_n),
        .resume        (resume),
        .waiting       (waiting),
        .irq           (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    seq_state_t  m_st;
    int unsigned m_steps, m_rem, m_comp, m_tmo, m_wd;
    bit          m_irq, m_tflag;
    logic [31:0] m_rdata;

    function automatic bit m_busy();
        return (m_st == ST_RUN) || (m_st == ST_RESUME) || (m_st == ST_DRAIN);
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_st) * 8 + 32'(m_irq) * 4 + 32'(m_tflag) * 2 + 32'(m_busy());
            2'd1:    return m_rem;
            2'd2:    return m_tmo;
            default: return m_comp;
        endcase
    endfunction

    task automatic model_step(input bit rs, input bit w, input bit r,
                              input logic [1:0] a, input logic [31:0] d, input bit wt);
        logic [31:0] rv;
        bit          busy, go, abort, clr, expire, counting;
        seq_state_t  ns;
        if (rs) begin
            m_st = ST_IDLE; m_steps = 0; m_rem = 0; m_comp = 0; m_tmo = 0; m_wd = 0;
            m_irq = 0; m_tflag = 0; m_rdata = '0;
            return;
        end
        rv       = m_read(a);
        busy     = m_busy();
        go       = w && (a == 2'd0) && d[0];
        abort    = w && (a == 2'd0) && d[1];
        clr      = w && (a == 2'd0) && d[2];
        expire   = (m_tmo != 0) && (m_wd + 1 >= m_tmo);
        counting = (m_st == ST_RUN) || (m_st == ST_DRAIN);
        ns       = m_st;
        if (r) m_rdata = rv;
        if (clr) m_irq = 0;
        if (abort) begin
            ns = ST_IDLE; m_wd = 0;
        end else if (go && !busy) begin
            ns = ST_RUN; m_rem = m_steps; m_comp = 0; m_tflag = 0; m_irq = 0; m_wd = 0;
        end else begin
            if (m_st == ST_RUN) begin
                if (wt) begin
                    if (m_rem > 0) begin
                        ns = ST_RESUME; m_rem--;
                        if (m_comp < 65535) m_comp++;
                    end else begin
                        ns = ST_DONE; m_irq = 1;
                    end
                end else if (expire) begin
                    ns = ST_TOUT; m_tflag = 1; m_irq = 1;
                end
            end else if (m_st == ST_RESUME) begin
                ns = ST_DRAIN;
            end else if (m_st == ST_DRAIN) begin
                if (!wt) ns = ST_RUN;
                else if (expire) begin
                    ns = ST_TOUT; m_tflag = 1; m_irq = 1;
                end
            end
            if (m_st == ST_DRAIN && ns == ST_RUN) m_wd = 0;
            else if (counting && m_tmo != 0) m_wd++;
        end
        if (w && !busy && a == 2'd1) begin
            m_steps = d & 32'h0000_FFFF;
            m_rem   = m_steps;
        end
        if (w && !busy && a == 2'd2) m_tmo = d & 32'h00FF_FFFF;
        m_st = ns;
    endtask

    // One clock: drive inputs, advance model, sample after the edge.
    task automatic step(input bit rs, input bit w, input bit r,
                        input logic [1:0] a, input logic [31:0] d, input bit wt);
        reset = rs; avl_write = w; avl_read = r; avl_address = a;
        avl_writedata = d; waiting = wt;
        model_step(rs, w, r, a, d, wt);
        @(posedge clk);
        #1;
        check("pause_n", 32'(pause_n), 32'(!(m_st == ST_IDLE || m_st == ST_TOUT)));
        check("resume", 32'(resume), 32'(m_st == ST_RESUME));
        check("irq", 32'(irq), 32'(m_irq));
        if (r || rs) check("readdata", avl_readdata, m_rdata);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit wt);
        step(1'b0, 1'b1, 1'b0, a, d, wt);
    endtask

    task automatic rd(input logic [1:0] a, input bit wt);
        step(1'b0, 1'b0, 1'b1, a, 32'd0, wt);
    endtask

    task automatic idle(input bit wt);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, wt);
    endtask

    initial begin
        int          nres;
        int          n;
        bit          rs, w, r, wt;
        logic [1:0]  a;
        logic [31:0] d;

        step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        check("rst_pause_n", 32'(pause_n), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), 1'b0);
            check("rst_reg", avl_readdata, 32'd0);
        end

        // Two steps, three sync points, no watchdog
        wr(2'd1, 32'd2, 1'b0);
        wr(2'd2, 32'd0, 1'b0);
        wr(2'd0, 32'd1, 1'b0);
        nres = 0;
        for (int p = 0; p < 3; p++) begin
            step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
            if (resume) nres++;
            for (int k = 0; k < 3; k++) begin
                idle(1'b0);
                if (resume) nres++;
            end
        end
        check("s1_resume_count", 32'(nres), 32'd2);
        rd(2'd3, 1'b0);
        check("s1_completed", avl_readdata, 32'd2);
        rd(2'd0, 1'b0);
        check("s1_status_done", avl_readdata, 32'd36);
        check("s1_pause_n", 32'(pause_n), 32'd1);
        check("s1_irq", 32'(irq), 32'd1);

        // Watchdog expiry with the core never reaching a sync point
        wr(2'd2, 32'd10, 1'b0);
        wr(2'd0, 32'd1, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1'b0);
            n++;
            if (!pause_n) break;
        end
        check("s2_tout_latency", 32'(n), 32'd10);
        rd(2'd0, 1'b0);
        check("s2_status_tout", avl_readdata, 32'd46);
        check("s2_pause_n", 32'(pause_n), 32'd0);
        check("s2_irq", 32'(irq), 32'd1);

        // Sync point arriving on the expiry cycle wins
        wr(2'd1, 32'd1, 1'b0);
        wr(2'd2, 32'd5, 1'b0);
        wr(2'd0, 32'd1, 1'b0);
        repeat (4) idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
        check("s3_resume", 32'(resume), 32'd1);
        rd(2'd0, 1'b0);
        check("s3_status_resume", avl_readdata, 32'd17);
        idle(1'b0);
        rd(2'd0, 1'b0);
        check("s3_status_run", avl_readdata, 32'd9);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
        idle(1'b0);

        // go|abort while draining with waiting held
        wr(2'd1, 32'd3, 1'b0);
        wr(2'd2, 32'd0, 1'b0);
        wr(2'd0, 32'd1, 1'b0);
        repeat (3) idle(1'b1);
        wr(2'd0, 32'd3, 1'b1);
        check("s4_pause_n", 32'(pause_n), 32'd0);
        check("s4_resume", 32'(resume), 32'd0);
        nres = 0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            if (resume) nres++;
        end
        check("s4_no_resume", 32'(nres), 32'd0);
        rd(2'd0, 1'b0);
        check("s4_status_idle", avl_readdata, 32'd0);

        // STEPS write locked out while busy
        wr(2'd1, 32'd4, 1'b0);
        wr(2'd0, 32'd1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        wr(2'd1, 32'd7, 1'b0);
        rd(2'd1, 1'b0);
        check("s5_steps_busy", avl_readdata, 32'd3);
        for (int p = 0; p < 4; p++) begin
            idle(1'b1);
            idle(1'b0);
            idle(1'b0);
        end
        rd(2'd0, 1'b0);
        check("s5_status_done", avl_readdata, 32'd36);
        wr(2'd1, 32'd7, 1'b0);
        rd(2'd1, 1'b0);
        check("s5_steps_idle", avl_readdata, 32'd7);

        // Reset in the middle of a release pulse
        wr(2'd1, 32'd2, 1'b0);
        wr(2'd0, 32'd1, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
        check("s6_pause_n", 32'(pause_n), 32'd0);
        check("s6_resume", 32'(resume), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), 1'b0);
            check("s6_reg_zero", avl_readdata, 32'd0);
        end

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rs = ($urandom_range(0, 199) == 0);
            w  = ($urandom_range(0, 3) == 0);
            r  = $urandom_range(0, 1);
            a  = 2'($urandom_range(0, 3));
            wt = ($urandom_range(0, 9) < 4);
            case (a)
                2'd0: begin
                    d    = $urandom;
                    d[1] = ($urandom_range(0, 7) == 0);
                end
                2'd1:    d = $urandom_range(0, 4);
                2'd2:    d = $urandom_range(0, 15);
                default: d = $urandom;
            endcase
            step(rs, w, r, a, d, wt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
